cachepool_l2_arbiter: RTL and testbench

CACHEPOOL_L2_ARBITER -- requirements
Module: cachepool_l2_arbiter

---
 rtl/cachepool_pkg.sv | 23 ++
 rtl/cachepool_rr_arbiter.sv | 35 +++
 rtl/cachepool_l2_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_cachepool_l2_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cachepool_pkg.sv
// Shared definitions for the cachepool L2 channel arbiter: controller state
// type, default outstanding-transaction cap and a round-robin helper.
package cachepool_pkg;

    // Default per-requester in-flight transaction cap.
    localparam int unsigned DefaultMaxOutstanding = 4;

    // Channel controller states.
    //   ST_IDLE  : arbitrate and capture one request
    //   ST_ISSUE : present the captured request on the L2 channel
    //   ST_WDATA : forward the write burst of the issued request
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WDATA = 2'd2
    } state_e;

    // Index following idx in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cachepool_rr_arbiter.sv
// Combinational round-robin select: the first set bit of mask found when
// scanning upward from ptr (wrapping at NumReq) wins. Returns both the
// binary index and a one-hot grant vector.
module cachepool_rr_arbiter #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0]   mask,
    input  logic [IdxWidth-1:0] ptr,
    output logic                gnt_valid,
    output logic [IdxWidth-1:0] gnt_idx,
    output logic [NumReq-1:0]   gnt_onehot
);

    logic [IdxWidth-1:0] cand;

    // Scan candidates in priority order ptr, ptr+1, ...; the first hit wins.
    // NOTE: every output and temporary gets a default before the loop so
    // no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        cand       = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            cand = IdxWidth'((int'(ptr) + k) % int'(NumReq));
            if (!gnt_valid && mask[cand]) begin
                gnt_valid        = 1'b1;
                gnt_idx          = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cachepool_l2_arbiter.sv
// Shares one L2 request/write/response channel among NumReq requesters.
// One request is captured at a time: it is arbitrated in IDLE, presented
// on the channel in ISSUE and, for writes, its burst is steered through in
// WDATA. A per-requester counter caps in-flight transactions; responses are
// routed back combinationally by index and retire transactions on their
// last beat.
module cachepool_l2_arbiter
    import cachepool_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
    localparam int unsigned IdxWidth      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    // requester-side request channel
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0]                   req_write_i,
    input  logic [NumReq-1:0][7:0]              req_len_i,
    // L2 request channel
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [AddrWidth-1:0]                out_addr_o,
    output logic                                out_write_o,
    output logic [7:0]                          out_len_o,
    output logic [IdxWidth-1:0]                 out_idx_o,
    // write beat handshake (data is muxed externally by w_sel_o)
    input  logic [NumReq-1:0]                   w_valid_i,
    output logic [NumReq-1:0]                   w_ready_o,
    output logic                                out_w_valid_o,
    input  logic                                out_w_ready_i,
    output logic [IdxWidth-1:0]                 w_sel_o,
    // response routing
    input  logic                                rsp_valid_i,
    output logic                                rsp_ready_o,
    input  logic [IdxWidth-1:0]                 rsp_idx_i,
    input  logic                                rsp_last_i,
    output logic [NumReq-1:0]                   rsp_valid_o,
    input  logic [NumReq-1:0]                   rsp_ready_i
);

    // Wide enough to hold 0..MaxOutstanding inclusive.
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    state_e                 state_q;
    logic [IdxWidth-1:0]    rr_ptr_q;
    logic [7:0]             beat_q;
    logic [AddrWidth-1:0]   out_addr_q;
    logic                   out_write_q;
    logic [7:0]             out_len_q;
    logic [IdxWidth-1:0]    out_idx_q;
    logic [CntWidth-1:0]    cnt_q [NumReq];

    logic [NumReq-1:0]      eligible;
    logic                   gnt_valid;
    logic [IdxWidth-1:0]    gnt_idx;
    logic [NumReq-1:0]      gnt_onehot;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   w_last;
    logic                   rsp_in_range;
    logic                   rsp_retire;
    logic [NumReq-1:0]      cnt_inc;
    logic [NumReq-1:0]      cnt_dec;
    logic                   cnt_underflow;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // A requester competes only while it has room for another transaction.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
        end
    end

    cachepool_rr_arbiter #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_arbiter (
        .mask       (eligible),
        .ptr        (rr_ptr_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    // Accept only in IDLE; no lookahead while a request is in flight.
    assign req_ready_o = (state_q == ST_IDLE && !rst_i) ? gnt_onehot : '0;

    // ------------------------------------------------------------------
    // Channel outputs
    // ------------------------------------------------------------------

    assign out_valid_o = (state_q == ST_ISSUE);
    assign out_addr_o  = out_addr_q;
    assign out_write_o = out_write_q;
    assign out_len_o   = out_len_q;
    assign out_idx_o   = out_idx_q;
    assign w_sel_o     = out_idx_q;

    assign aw_hs  = out_valid_o && out_ready_i;
    assign w_hs   = out_w_valid_o && out_w_ready_i;
    assign w_last = (beat_q == out_len_q);

    // Steer the write-beat handshake between the granted requester and L2.
    always_comb begin
        out_w_valid_o = 1'b0;
        w_ready_o     = '0;
        if (state_q == ST_WDATA) begin
            out_w_valid_o        = w_valid_i[out_idx_q];
            w_ready_o[out_idx_q] = out_w_ready_i;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------

    assign rsp_in_range = (32'(rsp_idx_i) < NumReq);

    // Route responses by index; out-of-range indices are drained so the
    // channel never stalls on a response nobody can take.
    always_comb begin
        rsp_valid_o = '0;
        rsp_ready_o = 1'b0;
        if (!rst_i) begin
            if (rsp_in_range) begin
                rsp_valid_o[rsp_idx_i] = rsp_valid_i;
                rsp_ready_o            = rsp_ready_i[rsp_idx_i];
            end else begin
                rsp_ready_o = 1'b1;
            end
        end
    end

    assign rsp_retire = rsp_valid_i && rsp_ready_o && rsp_last_i && rsp_in_range;

    // ------------------------------------------------------------------
    // Outstanding counters
    // ------------------------------------------------------------------

    // Per-requester increment on issue and decrement on last response beat.
    always_comb begin
        cnt_inc       = '0;
        cnt_dec       = '0;
        cnt_underflow = 1'b0;
        for (int i = 0; i < int'(NumReq); i++) begin
            cnt_inc[i] = aw_hs && (out_idx_q == IdxWidth'(i));
            cnt_dec[i] = rsp_retire && (rsp_idx_i == IdxWidth'(i));
            if (cnt_dec[i] && !cnt_inc[i] && cnt_q[i] == '0) begin
                cnt_underflow = 1'b1;
            end
        end
    end

    // Update counters; a same-cycle issue and retire cancel, and a retire
    // at zero is ignored rather than wrapping.
    // NOTE: the counter array is reset element by element because arbitration
    // reads it from the first cycle after reset; it is a handful of flops,
    // not a RAM, so there is no cost to clearing it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumReq); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NumReq); i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CntWidth'(1);
                end else if (cnt_dec[i] && !cnt_inc[i] && cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - CntWidth'(1);
                end
            end
        end
    end

    // A retire with nothing outstanding means the L2 side lost track.
    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i) !cnt_underflow);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------

    // Capture, issue and write-burst sequencing; reset abandons any
    // transaction in progress.
    // NOTE: all state here is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            beat_q      <= '0;
            out_addr_q  <= '0;
            out_write_q <= 1'b0;
            out_len_q   <= '0;
            out_idx_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        out_addr_q  <= req_addr_i[gnt_idx];
                        out_write_q <= req_write_i[gnt_idx];
                        out_len_q   <= req_len_i[gnt_idx];
                        out_idx_q   <= gnt_idx;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (out_ready_i) begin
                        rr_ptr_q <= IdxWidth'(rr_next(32'(out_idx_q), NumReq));
                        beat_q   <= '0;
                        state_q  <= out_write_q ? ST_WDATA : ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        if (w_last) begin
                            beat_q  <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cachepool_l2_arbiter.sv
// Directed bench for cachepool_l2_arbiter. Five requesters are used so that
// a 3-bit response index can name a requester that does not exist.
module tb_cachepool_l2_arbiter;

    localparam int N  = 5;
    localparam int AW = 48;
    localparam int IW = 3;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [N-1:0]       req_valid_i;
    logic [N-1:0]       req_ready_o;
    logic [N-1:0][AW-1:0] req_addr_i;
    logic [N-1:0]       req_write_i;
    logic [N-1:0][7:0]  req_len_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [AW-1:0]      out_addr_o;
    logic               out_write_o;
    logic [7:0]         out_len_o;
    logic [IW-1:0]      out_idx_o;
    logic [N-1:0]       w_valid_i;
    logic [N-1:0]       w_ready_o;
    logic               out_w_valid_o;
    logic               out_w_ready_i;
    logic [IW-1:0]      w_sel_o;
    logic               rsp_valid_i;
    logic               rsp_ready_o;
    logic [IW-1:0]      rsp_idx_i;
    logic               rsp_last_i;
    logic [N-1:0]       rsp_valid_o;
    logic [N-1:0]       rsp_ready_i;

    int tests  = 0;
    int failed = 0;

    cachepool_l2_arbiter #(
        .NumReq         (N),
        .AddrWidth      (AW),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_write_i   (req_write_i),
        .req_len_i     (req_len_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_addr_o    (out_addr_o),
        .out_write_o   (out_write_o),
        .out_len_o     (out_len_o),
        .out_idx_o     (out_idx_o),
        .w_valid_i     (w_valid_i),
        .w_ready_o     (w_ready_o),
        .out_w_valid_o (out_w_valid_o),
        .out_w_ready_i (out_w_ready_i),
        .w_sel_o       (w_sel_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_ready_o   (rsp_ready_o),
        .rsp_idx_i     (rsp_idx_i),
        .rsp_last_i    (rsp_last_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i   = '0;
        req_addr_i    = '0;
        req_write_i   = '0;
        req_len_i     = '0;
        out_ready_i   = 1'b0;
        w_valid_i     = '0;
        out_w_ready_i = 1'b0;
        rsp_valid_i   = 1'b0;
        rsp_idx_i     = '0;
        rsp_last_i    = 1'b0;
        rsp_ready_i   = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Present one request from requester idx and wait up to budget cycles
    // for acceptance. waited = cycles before acceptance, or -1 if never
    // accepted. When accepted, the request is also taken by the channel,
    // leaving the DUT in the cycle after the channel handshake.
    task automatic do_request(input int idx, input bit wr, input logic [7:0] len,
                              input logic [AW-1:0] addr, input int budget, output int waited);
        req_valid_i[idx] = 1'b1;
        req_write_i[idx] = wr;
        req_len_i[idx]   = len;
        req_addr_i[idx]  = addr;
        waited = -1;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (req_ready_o[idx]) begin
                waited = c;
                break;
            end
            tick();
        end
        if (waited >= 0) begin
            tick();
            req_valid_i[idx] = 1'b0;
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
        end else begin
            req_valid_i[idx] = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i         = 1'b1;
        req_valid_i   = '1;
        w_valid_i     = '1;
        out_w_ready_i = 1'b1;
        rsp_valid_i   = 1'b1;
        rsp_idx_i     = 3'd0;
        rsp_ready_i   = '1;
        tick();
        tests++; if (req_ready_o !== 5'b00000) begin failed++; $display("FAIL reset_req_ready: got %b want 00000", req_ready_o); end
        tests++; if (rsp_valid_o !== 5'b00000) begin failed++; $display("FAIL reset_rsp_valid: got %b want 00000", rsp_valid_o); end
        tests++; if (rsp_ready_o !== 1'b0) begin failed++; $display("FAIL reset_rsp_ready: got %b want 0", rsp_ready_o); end
        tests++; if ({out_valid_o, out_w_valid_o} !== 2'b00) begin failed++; $display("FAIL reset_out_valid: got %b want 00", {out_valid_o, out_w_valid_o}); end
        tests++; if (w_ready_o !== 5'b00000) begin failed++; $display("FAIL reset_w_ready: got %b want 00000", w_ready_o); end
        tests++; if ({out_addr_o, out_len_o, out_write_o, out_idx_o} !== '0) begin failed++; $display("FAIL reset_out_regs: addr %h len %h wr %b idx %0d want all 0", out_addr_o, out_len_o, out_write_o, out_idx_o); end
        clear_inputs();
        rst_i = 1'b0;
        #1;
        tests++; if ({out_valid_o, req_ready_o} !== 6'b0) begin failed++; $display("FAIL reset_release_idle: got %b want 000000", {out_valid_o, req_ready_o}); end
    endtask

    task automatic test_rr_reads();
        reset_dut();
        req_valid_i   = 5'b00101;
        req_addr_i[0] = 48'h0000_1000_0000;
        req_addr_i[2] = 48'h0000_2000_0040;
        #1;
        tests++; if (req_ready_o !== 5'b00001) begin failed++; $display("FAIL rr_first_grant: got %b want 00001", req_ready_o); end
        tick();
        tests++; if (out_valid_o !== 1'b1) begin failed++; $display("FAIL rr_issue0_valid: got %b want 1", out_valid_o); end
        tests++; if (out_idx_o !== 3'd0 || out_addr_o !== 48'h0000_1000_0000 || out_write_o !== 1'b0) begin failed++; $display("FAIL rr_issue0_fields: idx %0d addr %h wr %b want 0 000010000000 0", out_idx_o, out_addr_o, out_write_o); end
        tests++; if (req_ready_o !== 5'b00000) begin failed++; $display("FAIL rr_no_lookahead: got %b want 00000", req_ready_o); end
        req_addr_i[0] = 48'h0000_3000_0000;
        tick();
        tests++; if (out_valid_o !== 1'b1 || out_addr_o !== 48'h0000_1000_0000) begin failed++; $display("FAIL rr_issue0_hold: valid %b addr %h want 1 000010000000", out_valid_o, out_addr_o); end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        #1;
        tests++; if (req_ready_o !== 5'b00100) begin failed++; $display("FAIL rr_second_grant: got %b want 00100", req_ready_o); end
        tick();
        tests++; if (out_valid_o !== 1'b1 || out_idx_o !== 3'd2 || out_addr_o !== 48'h0000_2000_0040) begin failed++; $display("FAIL rr_issue2: valid %b idx %0d addr %h want 1 2 000020000040", out_valid_o, out_idx_o, out_addr_o); end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        #1;
        tests++; if (req_ready_o !== 5'b00001) begin failed++; $display("FAIL rr_wrap_grant: got %b want 00001", req_ready_o); end
        clear_inputs();
    endtask

    task automatic test_write_burst();
        int beats;
        reset_dut();
        req_valid_i    = 5'b01010;
        req_write_i[1] = 1'b1;
        req_len_i[1]   = 8'd3;
        req_addr_i[1]  = 48'h0000_0000_0800;
        req_addr_i[3]  = 48'h0000_0000_0C00;
        #1;
        tests++; if (req_ready_o !== 5'b00010) begin failed++; $display("FAIL wr_grant1: got %b want 00010", req_ready_o); end
        tick();
        req_valid_i[1] = 1'b0;
        out_ready_i    = 1'b1;
        #1;
        tests++; if (out_write_o !== 1'b1 || out_len_o !== 8'd3 || out_idx_o !== 3'd1) begin failed++; $display("FAIL wr_issue_fields: wr %b len %0d idx %0d want 1 3 1", out_write_o, out_len_o, out_idx_o); end
        tick();
        out_ready_i = 1'b0;
        w_valid_i   = 5'b01010;
        beats = 0;
        for (int c = 0; c < 8; c++) begin
            out_w_ready_i = (c % 2 == 1);
            #1;
            tests++; if (out_w_valid_o !== 1'b1 || w_sel_o !== 3'd1) begin failed++; $display("FAIL wr_beat_fwd c%0d: wvalid %b sel %0d want 1 1", c, out_w_valid_o, w_sel_o); end
            tests++; if (w_ready_o !== ((c % 2 == 1) ? 5'b00010 : 5'b00000)) begin failed++; $display("FAIL wr_beat_ready c%0d: got %b", c, w_ready_o); end
            tests++; if (req_ready_o !== 5'b00000) begin failed++; $display("FAIL wr_req3_early c%0d: got %b want 00000", c, req_ready_o); end
            if (out_w_valid_o && out_w_ready_i) beats++;
            tick();
        end
        tests++; if (beats != 4) begin failed++; $display("FAIL wr_beat_count: got %0d want 4", beats); end
        tests++; if (out_w_valid_o !== 1'b0 || w_ready_o !== 5'b00000) begin failed++; $display("FAIL wr_burst_end: wvalid %b wready %b want 0 00000", out_w_valid_o, w_ready_o); end
        tests++; if (req_ready_o !== 5'b01000) begin failed++; $display("FAIL wr_req3_after: got %b want 01000", req_ready_o); end
        clear_inputs();
    endtask

    task automatic test_len0_write();
        reset_dut();
        req_valid_i[4] = 1'b1;
        req_write_i[4] = 1'b1;
        req_len_i[4]   = 8'd0;
        #1;
        tests++; if (req_ready_o !== 5'b10000) begin failed++; $display("FAIL len0_grant: got %b want 10000", req_ready_o); end
        tick();
        req_valid_i = 5'b00001;
        out_ready_i = 1'b1;
        tick();
        out_ready_i   = 1'b0;
        w_valid_i     = 5'b10000;
        out_w_ready_i = 1'b1;
        #1;
        tests++; if (out_w_valid_o !== 1'b1 || w_ready_o !== 5'b10000) begin failed++; $display("FAIL len0_beat: wvalid %b wready %b want 1 10000", out_w_valid_o, w_ready_o); end
        tick();
        tests++; if (out_w_valid_o !== 1'b0) begin failed++; $display("FAIL len0_single_beat: wvalid %b want 0", out_w_valid_o); end
        tests++; if (req_ready_o !== 5'b00001) begin failed++; $display("FAIL len0_back_idle: got %b want 00001", req_ready_o); end
        clear_inputs();
    endtask

    task automatic test_outstanding();
        int w;
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            do_request(0, 1'b0, 8'd0, AW'(48'h100 + k), 4, w);
            tests++; if (w != 0) begin failed++; $display("FAIL cap_fill%0d: waited %0d want 0", k, w); end
        end
        do_request(0, 1'b0, 8'd0, 48'h200, 3, w);
        tests++; if (w != -1) begin failed++; $display("FAIL cap_fifth_blocked: waited %0d want -1", w); end
        // non-last beat to requester 0 must not free a slot
        rsp_valid_i = 1'b1; rsp_idx_i = 3'd0; rsp_last_i = 1'b0; rsp_ready_i = '1;
        #1;
        tests++; if (rsp_valid_o !== 5'b00001 || rsp_ready_o !== 1'b1) begin failed++; $display("FAIL cap_rsp_route: valid %b ready %b want 00001 1", rsp_valid_o, rsp_ready_o); end
        tick();
        rsp_valid_i = 1'b0;
        do_request(0, 1'b0, 8'd0, 48'h200, 2, w);
        tests++; if (w != -1) begin failed++; $display("FAIL cap_nonlast_kept: waited %0d want -1", w); end
        // responses to nonexistent requesters are drained and ignored
        rsp_valid_i = 1'b1; rsp_idx_i = 3'd5; rsp_last_i = 1'b1; rsp_ready_i = '0;
        #1;
        tests++; if (rsp_ready_o !== 1'b1 || rsp_valid_o !== 5'b00000) begin failed++; $display("FAIL oor_idx5: ready %b valid %b want 1 00000", rsp_ready_o, rsp_valid_o); end
        tick();
        rsp_idx_i = 3'd7;
        #1;
        tests++; if (rsp_ready_o !== 1'b1 || rsp_valid_o !== 5'b00000) begin failed++; $display("FAIL oor_idx7: ready %b valid %b want 1 00000", rsp_ready_o, rsp_valid_o); end
        tick();
        rsp_valid_i = 1'b0;
        do_request(0, 1'b0, 8'd0, 48'h200, 2, w);
        tests++; if (w != -1) begin failed++; $display("FAIL oor_counts_kept: waited %0d want -1", w); end
        // last beat to requester 0 frees one slot
        rsp_valid_i = 1'b1; rsp_idx_i = 3'd0; rsp_last_i = 1'b1; rsp_ready_i = 5'b00001;
        #1;
        tests++; if (rsp_valid_o !== 5'b00001 || rsp_ready_o !== 1'b1) begin failed++; $display("FAIL cap_last_route: valid %b ready %b want 00001 1", rsp_valid_o, rsp_ready_o); end
        tick();
        clear_inputs();
        do_request(0, 1'b0, 8'd0, 48'h200, 2, w);
        tests++; if (w != 0) begin failed++; $display("FAIL cap_fifth_granted: waited %0d want 0", w); end
    endtask

    task automatic test_simul_inc_dec();
        int w;
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            do_request(2, 1'b0, 8'd0, AW'(48'h400 + k), 4, w);
            tests++; if (w != 0) begin failed++; $display("FAIL sim_fill%0d: waited %0d want 0", k, w); end
        end
        req_valid_i[2] = 1'b1;
        #1;
        tests++; if (req_ready_o !== 5'b00100) begin failed++; $display("FAIL sim_grant: got %b want 00100", req_ready_o); end
        tick();
        req_valid_i[2] = 1'b0;
        out_ready_i = 1'b1;
        rsp_valid_i = 1'b1; rsp_idx_i = 3'd2; rsp_last_i = 1'b1; rsp_ready_i = '1;
        #1;
        tests++; if (out_valid_o !== 1'b1 || rsp_valid_o !== 5'b00100) begin failed++; $display("FAIL sim_same_cycle: out_valid %b rsp_valid %b want 1 00100", out_valid_o, rsp_valid_o); end
        tick();
        clear_inputs();
        // count must still be 2: exactly two more fit, the third is blocked
        for (int k = 0; k < 2; k++) begin
            do_request(2, 1'b0, 8'd0, AW'(48'h500 + k), 4, w);
            tests++; if (w != 0) begin failed++; $display("FAIL sim_refill%0d: waited %0d want 0", k, w); end
        end
        do_request(2, 1'b0, 8'd0, 48'h600, 3, w);
        tests++; if (w != -1) begin failed++; $display("FAIL sim_full: waited %0d want -1", w); end
    endtask

    task automatic test_reset_mid_wdata();
        int w;
        reset_dut();
        do_request(1, 1'b1, 8'd7, 48'h0000_0000_0900, 4, w);
        tests++; if (w != 0) begin failed++; $display("FAIL rstw_grant: waited %0d want 0", w); end
        w_valid_i     = 5'b00010;
        out_w_ready_i = 1'b1;
        req_valid_i[3] = 1'b1;
        rsp_valid_i = 1'b1; rsp_idx_i = 3'd0; rsp_ready_i = '1;
        tick();
        tests++; if (out_w_valid_o !== 1'b1 || w_ready_o !== 5'b00010) begin failed++; $display("FAIL rstw_beat2: wvalid %b wready %b want 1 00010", out_w_valid_o, w_ready_o); end
        rst_i = 1'b1;
        #1;
        tests++; if ({out_valid_o, out_w_valid_o, rsp_ready_o} !== 3'b000 || w_ready_o !== 5'b0 || req_ready_o !== 5'b0 || rsp_valid_o !== 5'b0) begin failed++; $display("FAIL rstw_async: ov %b wv %b rr %b wr %b qr %b rv %b want all 0", out_valid_o, out_w_valid_o, rsp_ready_o, w_ready_o, req_ready_o, rsp_valid_o); end
        tick();
        tests++; if ({out_valid_o, out_w_valid_o, rsp_ready_o} !== 3'b000 || w_ready_o !== 5'b0 || req_ready_o !== 5'b0 || rsp_valid_o !== 5'b0) begin failed++; $display("FAIL rstw_next: ov %b wv %b rr %b wr %b qr %b rv %b want all 0", out_valid_o, out_w_valid_o, rsp_ready_o, w_ready_o, req_ready_o, rsp_valid_o); end
        tests++; if ({out_addr_o, out_len_o, out_write_o, out_idx_o, w_sel_o} !== '0) begin failed++; $display("FAIL rstw_regs: addr %h len %h wr %b idx %0d sel %0d want all 0", out_addr_o, out_len_o, out_write_o, out_idx_o, w_sel_o); end
        rsp_valid_i = 1'b0;
        w_valid_i = '0;
        out_w_ready_i = 1'b0;
        rst_i = 1'b0;
        #1;
        tests++; if (req_ready_o !== 5'b01000 || out_w_valid_o !== 1'b0) begin failed++; $display("FAIL rstw_idle: req_ready %b wvalid %b want 01000 0", req_ready_o, out_w_valid_o); end
        req_valid_i = '0;
        // counter of requester 1 must be back at 0: four fit, the fifth waits
        for (int k = 0; k < 4; k++) begin
            do_request(1, 1'b0, 8'd0, AW'(48'h700 + k), 4, w);
            tests++; if (w != 0) begin failed++; $display("FAIL rstw_cnt%0d: waited %0d want 0", k, w); end
        end
        do_request(1, 1'b0, 8'd0, 48'h800, 2, w);
        tests++; if (w != -1) begin failed++; $display("FAIL rstw_cnt_cap: waited %0d want -1", w); end
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        test_reset();
        test_rr_reads();
        test_write_burst();
        test_len0_write();
        test_outstanding();
        test_simul_inc_dec();
        test_reset_mid_wdata();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
